// File: rtl/robot_sprite_pkg.sv
// Shared Rojobot sprite memory layout plus the loader state encoding.
// The icon read path and the loader both import this, so the address map stays identical.
package robot_sprite_pkg;
   localparam int SPRITE_COLS    = 34;
   localparam int SPRITE_ROWS    = 34;
   localparam int NUM_FRAME_COLS = 3;
   localparam int NUM_FRAME_ROWS = 8;
   localparam int MEM_COLS       = SPRITE_COLS * NUM_FRAME_COLS;
   localparam int MEM_ROWS       = SPRITE_ROWS * NUM_FRAME_ROWS;
   localparam int FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;

   localparam logic [11:0] TRANSPARENT_KEY = 12'h000;

   typedef enum logic [1:0] {IDLE, RUN, DONE} loader_state_e;
endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite write address generator: the frame base is latched on clear, then x/y/row_off advance on each step.
// The address is combinational from the registered counters; there is no multiply in the per-pixel path.
module sprite_addr_gen
   import robot_sprite_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              step_i,
   input  logic [2:0]        frame_row_i,
   input  logic [1:0]        frame_col_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);
   localparam int X_W = $clog2(SPRITE_COLS);
   localparam int Y_W = $clog2(SPRITE_ROWS + 1);
   localparam logic [X_W-1:0] X_LAST = X_W'(SPRITE_COLS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(SPRITE_ROWS - 1);

   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] row_off_q, row_off_d;
   logic [ADDR_W-1:0] base_q, base_d;

   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      row_off_d = row_off_q;
      base_d    = base_q;
      if (clear_i) begin
         base_d    = ADDR_W'(frame_row_i) * ADDR_W'(FRAME_ROW_SIZE)
                   + ADDR_W'(frame_col_i) * ADDR_W'(SPRITE_COLS);
         x_d       = '0;
         y_d       = '0;
         row_off_d = '0;
      end else if (step_i) begin
         if (x_q == X_LAST) begin
            x_d       = '0;
            y_d       = y_q + 1'b1;
            row_off_d = row_off_q + ADDR_W'(MEM_COLS);
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q       <= '0;
         y_q       <= '0;
         row_off_q <= '0;
         base_q    <= '0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         row_off_q <= row_off_d;
         base_q    <= base_d;
      end
   end

   assign addr_o = base_q + row_off_q + ADDR_W'(x_q);
   assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);
endmodule

// File: rtl/sprite_ram_loader.sv
// Streams 12-bit pixels into one sprite frame of the sprite RAM; 1-cycle accept-to-write latency.
// pix_ready is a registered state decode (high only in RUN); abort takes priority over a same-cycle accept.
module sprite_ram_loader
   import robot_sprite_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        frame_row,
   input  logic [1:0]        frame_col,
   input  logic              abort,
   input  logic              pix_valid,
   input  logic [11:0]       pix_data,
   output logic              pix_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [11:0]       ram_wdata,
   output logic              busy,
   output logic              done,
   output logic              start_err
);
   loader_state_e     state_q;
   logic              col_ok;
   logic              load_go;
   logic              accept;
   logic              step;
   logic              last_pix;
   logic [ADDR_W-1:0] addr;

   assign col_ok  = int'(frame_col) < NUM_FRAME_COLS;
   assign load_go = (state_q == IDLE) && start && col_ok;
   assign accept  = (state_q == RUN) && pix_valid && pix_ready;
   assign step    = accept && !abort;

   sprite_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (load_go),
      .step_i      (step),
      .frame_row_i (frame_row),
      .frame_col_i (frame_col),
      .addr_o      (addr),
      .last_o      (last_pix)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pix_ready <= 1'b0;
         ram_we    <= 1'b0;
         ram_waddr <= '0;
         ram_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         start_err <= 1'b0;
      end else begin
         ram_we    <= 1'b0;
         done      <= 1'b0;
         start_err <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !col_ok) begin
                  start_err <= 1'b1;
               end else if (load_go) begin
                  state_q   <= RUN;
                  busy      <= 1'b1;
                  pix_ready <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q   <= IDLE;
                  busy      <= 1'b0;
                  pix_ready <= 1'b0;
               end else if (accept) begin
                  ram_we    <= 1'b1;
                  ram_waddr <= addr;
                  ram_wdata <= pix_data;
                  // done is raised alongside the final write strobe
                  if (last_pix) begin
                     state_q   <= DONE;
                     pix_ready <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: a queue scoreboard of expected writes, checked at each strobe.
module tb_sprite_ram_loader;
   localparam int COLS  = 34;
   localparam int MCOLS = 102;
   localparam int FRS   = 3468;
   localparam int NPIX  = 1156;

   typedef struct packed {
      logic [14:0] addr;
      logic [11:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  frame_row;
   logic [1:0]  frame_col;
   logic        abort;
   logic        pix_valid;
   logic [11:0] pix_data;
   logic        pix_ready;
   logic        ram_we;
   logic [14:0] ram_waddr;
   logic [11:0] ram_wdata;
   logic        busy;
   logic        done;
   logic        start_err;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   wr_cnt, done_cnt;
   int   first_addr, last_addr, max_addr;

   sprite_ram_loader #(.ADDR_W(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .frame_row (frame_row),
      .frame_col (frame_col),
      .abort     (abort),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_ready (pix_ready),
      .ram_we    (ram_we),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .busy      (busy),
      .done      (done),
      .start_err (start_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (ram_we) begin
         wr_cnt++;
         if (wr_cnt == 1) first_addr = int'(ram_waddr);
         last_addr = int'(ram_waddr);
         if (int'(ram_waddr) > max_addr) max_addr = int'(ram_waddr);
         chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("waddr", 32'(ram_waddr), 32'(e.addr));
            chk("wdata", 32'(ram_wdata), 32'(e.data));
            chk("done_with_last", 32'(done), 32'(e.last));
         end
      end else if (done) begin
         chk("done_without_write", 32'(ram_we), 32'd1);
      end
      if (done) done_cnt++;
   end

   task automatic clear_stats();
      wr_cnt = 0; done_cnt = 0; first_addr = -1; last_addr = -1; max_addr = 0;
   endtask

   task automatic do_start(input int row, input int col);
      @(posedge clk); #1;
      start = 1'b1; frame_row = 3'(row); frame_col = 2'(col);
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_ready", 32'(pix_ready), 32'd1);
   endtask

   task automatic feed(input int row, input int col, input int n, input bit rnd);
      int   cnt = 0;
      int   guard = 0;
      exp_t e;
      while (cnt < n && guard < 6000) begin
         if (pix_ready && (!rnd || $urandom_range(0, 1) == 1)) begin
            pix_valid = 1'b1;
            pix_data  = 12'(cnt);
            e.addr = 15'(row * FRS + col * COLS + (cnt / COLS) * MCOLS + (cnt % COLS));
            e.data = 12'(cnt);
            e.last = (cnt == NPIX - 1);
            exp_q.push_back(e);
            cnt++;
         end else begin
            pix_valid = 1'b0;
         end
         @(posedge clk); #1;
         guard++;
      end
      pix_valid = 1'b0;
      chk("feed_budget", 32'(cnt), 32'(n));
   endtask

   // Leaves the bench just past the negedge of the done cycle.
   task automatic wait_done();
      int guard = 0;
      while (!done && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("done_seen", 32'(done), 32'd1);
      #5;
   endtask

   task automatic check_full(input int first_a, input int last_a);
      chk("first_addr", 32'(first_addr), 32'(first_a));
      chk("last_addr", 32'(last_addr), 32'(last_a));
      chk("write_count", 32'(wr_cnt), 32'(NPIX));
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; frame_row = '0; frame_col = '0;
      abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
      clear_stats();
      repeat (3) @(posedge clk); #1;
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(pix_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(start_err), 32'd0);
      chk("rst_addr", 32'(ram_waddr), 32'd0);
      reset = 1'b0;

      // Reset in the middle of a load
      clear_stats();
      do_start(0, 0);
      feed(0, 0, 10, 1'b0);
      #6 reset = 1'b1;
      #1;
      chk("mid_rst_we", 32'(ram_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(pix_ready), 32'd0);
      chk("mid_rst_addr", 32'(ram_waddr), 32'd0);
      chk("mid_rst_data", 32'(ram_wdata), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("mid_rst_writes", 32'(wr_cnt), 32'd10);
      chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);

      // Full load, valid held high
      clear_stats();
      do_start(3, 1);
      feed(3, 1, NPIX, 1'b0);
      wait_done();
      check_full(10438, 13837);
      @(posedge clk); #1;
      chk("post_done_busy", 32'(busy), 32'd0);
      chk("post_done_pulse", 32'(done), 32'd0);

      // Same load, random valid
      clear_stats();
      do_start(3, 1);
      feed(3, 1, NPIX, 1'b1);
      wait_done();
      check_full(10438, 13837);

      // Illegal column
      @(posedge clk); #1;
      start = 1'b1; frame_row = 3'd0; frame_col = 2'd3;
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_pulse", 32'(start_err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_ready", 32'(pix_ready), 32'd0);
      chk("err_we", 32'(ram_we), 32'd0);
      @(posedge clk); #1;
      chk("err_one_cycle", 32'(start_err), 32'd0);
      chk("err_still_idle", 32'(busy), 32'd0);

      // Abort together with the 50th accept
      clear_stats();
      do_start(0, 0);
      feed(0, 0, 49, 1'b0);
      pix_valid = 1'b1; pix_data = 12'd49; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; pix_valid = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(pix_ready), 32'd0);
      chk("abort_we", 32'(ram_we), 32'd0);
      repeat (3) @(posedge clk); #1;
      chk("abort_writes", 32'(wr_cnt), 32'd49);
      chk("abort_last_addr", 32'(last_addr), 32'd116);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_queue", 32'(exp_q.size()), 32'd0);

      // Highest frame, then an immediate restart
      clear_stats();
      do_start(7, 2);
      feed(7, 2, NPIX, 1'b0);
      wait_done();
      check_full(24344, 27743);
      chk("max_in_range", 32'(max_addr < 27744), 32'd1);
      clear_stats();
      do_start(0, 2);
      feed(0, 2, NPIX, 1'b0);
      wait_done();
      check_full(68, 68 + 33 * MCOLS + 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
- Write-side counterpart of the Rojobot sprite reader: accepts a stream of 12-bit pixels and writes one complete sprite frame into the sprite RAM's write port.
- Target frame is selected by frame_row (orientation, 0..7) and frame_col (animation column, 0..2).
- Uses the same memory layout as the icon read path: addr = frame_row*FRAME_ROW_SIZE + frame_col*SPRITE_COLS + y*MEM_COLS + x.
- Sits between the MMIO/UART pixel source and the sprite ram_block, allowing sprites to be replaced at run time without re-synthesis.

Parameters:
- SPRITE_COLS, 34, sprite width in pixels.
- SPRITE_ROWS, 34, sprite height in pixels.
- NUM_FRAME_COLS, 3, animation columns per orientation row.
- NUM_FRAME_ROWS, 8, orientation rows.
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= MEM_ROWS*MEM_COLS.
- Derived: MEM_COLS = SPRITE_COLS*NUM_FRAME_COLS, MEM_ROWS = SPRITE_ROWS*NUM_FRAME_ROWS, FRAME_ROW_SIZE = MEM_COLS*SPRITE_ROWS.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to load a frame; sampled in IDLE only.
- frame_row  in  3  target orientation row, sampled with start.
- frame_col  in  2  target animation column, sampled with start.
- abort  in  1  synchronous cancel of an in-progress load.
- pix_valid  in  1  pixel source has data.
- pix_data  in  12  pixel colour; 12'h000 is the transparent key and is written unchanged.
- pix_ready  out  1  loader accepts a pixel this cycle.
- ram_we  out  1  write strobe to the sprite RAM.
- ram_waddr  out  ADDR_W  write address.
- ram_wdata  out  12  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a frame completes.
- start_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous): state=IDLE; every output 0; x, y, base and row_off counters 0.
- Handshake: a pixel is accepted on a rising edge where pix_valid && pix_ready. pix_valid may be held or dropped freely; no combinational path from pix_valid to pix_ready.
- IDLE: pix_ready=0, busy=0.
  - start with frame_col >= NUM_FRAME_COLS: start_err pulses next cycle; no write occurs; state stays IDLE.
  - Otherwise: register base = frame_row*FRAME_ROW_SIZE + frame_col*SPRITE_COLS (the only multiply, computed once); clear x, y and row_off; go to RUN. busy=1 from the next cycle.
- RUN: pix_ready=1.
  - Each accept registers ram_we=1, ram_waddr = base + row_off + x, ram_wdata = pix_data, visible in the cycle after the accept (1-cycle latency). ram_we=0 on cycles with no accept.
  - Counter update: x++. When x == SPRITE_COLS-1: x=0, y++, row_off += MEM_COLS (incremental; no per-pixel multiply).
  - Accept at x == SPRITE_COLS-1 and y == SPRITE_ROWS-1: go to DONE. pix_ready drops in the next cycle.
- DONE: done=1 for exactly one cycle, coinciding with the final ram_we. Then return to IDLE; busy=0 in the following cycle.
- start in RUN or DONE: ignored, with no start_err.
- abort in RUN: next state IDLE. An accept in the same cycle is discarded (abort wins): no ram_we for it. done is not asserted. Already-written pixels remain in RAM.
- Exactly SPRITE_COLS*SPRITE_ROWS writes per completed load. Addresses never leave the selected frame; the maximum address is MEM_ROWS*MEM_COLS-1.
- Reset mid-load: immediate return to IDLE with all outputs 0; a partial frame is left in RAM.

Decomposition:
- Package robot_sprite_pkg holds:
  - SPRITE_COLS/ROWS, NUM_FRAME_COLS/ROWS, MEM_COLS, MEM_ROWS, FRAME_ROW_SIZE;
  - the transparent key 12'h000;
  - the loader state enum {IDLE, RUN, DONE}.
- The icon reader also imports this package, keeping the layout identical on both sides.
- One sub-module, sprite_addr_gen: the x/y/row_off counters plus the base adder, with clear/step inputs and last-pixel and address outputs. The FSM stays in the top level.

Test Plan:
- Assert reset mid-load (after 10 pixels) -> all outputs 0 asynchronously; no further ram_we; busy=0; next start behaves normally.
- start with frame_row=3, frame_col=1, 1156 pixels of incrementing data, pix_valid held high:
  - first write at addr 10438 with data 0; write 34 at addr 10540;
  - last write at addr 13837 with data 1155;
  - done pulses with the last ram_we; exactly 1156 strobes.
- Same load with pix_valid toggled randomly (about 50% duty) -> addresses contiguous as above, one ram_we per accept, no gaps or duplicates.
- start with frame_col=3 -> start_err pulses once; busy, ram_we and pix_ready stay 0.
- Load frame_row=0, frame_col=0; abort asserted in the same cycle as the 50th accept -> 49 writes (last at addr 116); the 50th is discarded; no done; busy=0 next cycle.
- frame_row=7, frame_col=2, full load -> first address 24344, last address 27743; no address reaches 27744; a second start immediately after done is accepted.
